// File: rtl/demux2_stream.sv
// Purpose : 1-to-2 registered stream demux; steers each accepted word to channel s.
// Latency : 1 cycle from input accept to valid on the selected channel.
// Backpr. : in_ready drops only when the selected channel is full and not popping.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   d, s, in_valid    input word, channel select, producer valid
//   in_ready          combinational accept (depends on s, valid0/1, ready0/1 only)
//   y0/valid0/ready0  channel 0 single-entry output buffer + handshake
//   y1/valid1/ready1  channel 1 single-entry output buffer + handshake
//   cnt0, cnt1        per-channel delivered-word counters (wrap silently)
module demux2_stream #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  d,
  input  logic          s,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [W-1:0]  y0,
  output logic          valid0,
  input  logic          ready0,
  output logic [W-1:0]  y1,
  output logic          valid1,
  input  logic          ready1,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  logic [W-1:0]  y0_q, y0_d;
  logic [W-1:0]  y1_q, y1_d;
  logic          valid0_q, valid0_d;
  logic          valid1_q, valid1_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  logic room0, room1;
  logic acc, acc0, acc1;
  logic pop0, pop1;

  // A channel can take a word if it is empty or its current word leaves this cycle.
  assign room0 = !valid0_q || ready0;
  assign room1 = !valid1_q || ready1;

  // Only the selected channel gates the producer; the idle one never stalls it.
  assign in_ready = s ? room1 : room0;

  assign acc  = in_valid && in_ready;
  assign acc0 = acc && !s;
  assign acc1 = acc && s;
  assign pop0 = valid0_q && ready0;
  assign pop1 = valid1_q && ready1;

  always_comb begin
    y0_d     = y0_q;
    y1_d     = y1_q;
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    // Accept wins over pop so a same-cycle pop+accept keeps valid high (no bubble).
    // A pop alone drops valid but leaves the data register untouched.
    if (acc0) begin
      y0_d     = d;
      valid0_d = 1'b1;
    end else if (pop0) begin
      valid0_d = 1'b0;
    end

    if (acc1) begin
      y1_d     = d;
      valid1_d = 1'b1;
    end else if (pop1) begin
      valid1_d = 1'b0;
    end

    if (pop0) cnt0_d = cnt0_q + CW'(1);
    if (pop1) cnt1_d = cnt1_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q     <= '0;
      y1_q     <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
    end
  end

  assign y0     = y0_q;
  assign y1     = y1_q;
  assign valid0 = valid0_q;
  assign valid1 = valid1_q;
  assign cnt0   = cnt0_q;
  assign cnt1   = cnt1_q;

endmodule

// File: tb/tb_demux2_stream.sv
// Purpose : randomized + directed bench for demux2_stream against a queue-based model.
// Latency : model expects a word on its channel one edge after acceptance.
// Backpr. : model accepts only when the selected channel's queue has room.
module tb_demux2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic       s;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y0, y1;
  logic       valid0, valid1;
  logic       ready0, ready1;
  logic [7:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  // Each channel is a queue of capacity one; the last delivered/loaded word is
  // remembered separately because the data output keeps it after a pop.
  byte unsigned q0[$];
  byte unsigned q1[$];
  int           last0, last1;
  int           delivered0, delivered1;

  demux2_stream #(.W(8), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .valid0(valid0), .ready0(ready0),
    .y1(y1), .valid1(valid1), .ready1(ready1),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0 = 0;
    last1 = 0;
    delivered0 = 0;
    delivered1 = 0;
  endtask

  task automatic check_outputs();
    check("valid0", valid0, (q0.size() != 0));
    check("valid1", valid1, (q1.size() != 0));
    check("y0", y0, last0);
    check("y1", y1, last1);
    check("cnt0", cnt0, delivered0 % 256);
    check("cnt1", cnt1, delivered1 % 256);
  endtask

  // Called at a falling edge: drive one cycle of inputs, check in_ready,
  // advance the model by the transfers of the coming rising edge, then check.
  task automatic step(input bit v, input bit sel, input logic [7:0] dv,
                      input bit r0, input bit r1);
    bit room, take, pop0, pop1;
    in_valid = v;
    s        = sel;
    d        = dv;
    ready0   = r0;
    ready1   = r1;
    #1;
    pop0 = (q0.size() != 0) && r0;
    pop1 = (q1.size() != 0) && r1;
    room = sel ? ((q1.size() == 0) || pop1) : ((q0.size() == 0) || pop0);
    check("in_ready", in_ready, room);
    take = v && room;
    if (pop0) begin void'(q0.pop_front()); delivered0++; end
    if (pop1) begin void'(q1.pop_front()); delivered1++; end
    if (take) begin
      if (sel) begin q1.push_back(dv); last1 = dv; end
      else     begin q0.push_back(dv); last0 = dv; end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous pulse well inside the low clock phase.
  task automatic async_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid0", valid0, 0);
    check("rst_valid1", valid1, 0);
    check("rst_y0", y0, 0);
    check("rst_y1", y1, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; s = 1'b0; d = '0; ready0 = 1'b0; ready1 = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // 1: route to channel 0
    step(1, 0, 8'hAA, 1, 0);
    check("t1_y0", y0, 8'hAA);
    check("t1_valid0", valid0, 1);
    step(0, 0, 8'h00, 1, 0);
    check("t1_cnt0", cnt0, 1);
    check("t1_drained", valid0, 0);

    // 2: channel 1 with backpressure
    step(1, 1, 8'h53, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 8'h11, 0, 0);
      check("t2_held_y1", y1, 8'h53);
      check("t2_held_valid1", valid1, 1);
    end
    step(1, 1, 8'h11, 0, 1);
    check("t2_swap_y1", y1, 8'h11);
    check("t2_swap_valid1", valid1, 1);
    check("t2_cnt1", cnt1, 1);
    step(0, 0, 8'h00, 0, 1);

    // 3: channel 0 stalled does not stall channel 1
    step(1, 0, 8'hFF, 0, 1);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 8'(i), 0, 1);
      check("t3_y1_seq", y1, i);
      check("t3_y0_stall", y0, 8'hFF);
    end
    step(0, 0, 8'h00, 0, 1);

    // 4: full throughput on channel 0
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(8'h10 + i), 1, 0);
      check("t4_no_bubble", valid0, 1);
    end
    step(0, 0, 8'h00, 1, 0);

    // 5: counter wrap from a fresh reset
    async_reset();
    for (int i = 1; i <= 256; i++) begin
      step(1, 0, 8'(i), 1, 0);
    end
    check("t5_cnt0_ff", cnt0, 8'hFF);
    step(0, 0, 8'h00, 1, 0);
    check("t5_cnt0_wrap", cnt0, 8'h00);
    check("t5_cnt1", cnt1, 0);

    // 6: reset with both channels loaded
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 1, 0);
    step(1, 1, 8'h77, 1, 0);
    step(1, 0, 8'h66, 0, 0);
    check("t6_pre_cnt0", cnt0, 5);
    check("t6_pre_v", {valid0, valid1}, 2'b11);
    async_reset();
    step(0, 0, 8'h00, 1, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
           8'($urandom), bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1-to-2 registered stream demultiplexer; steers each input word to output channel 0 or 1 according to select `s`.
- Each output channel holds a single-entry buffer with valid/ready handshake.
- Per-channel delivery counters provide debug/verification visibility.
- Sits downstream of datapath muxes to fan a single result stream out to two consumers.

Parameters:
- W, 8, data width of input and both outputs
- CW, 8, width of per-channel delivered-word counters

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- d  input  W  input data word
- s  input  1  channel select (0 -> channel 0, 1 -> channel 1); sampled only on an accepted transfer
- in_valid  input  1  producer presents d/s this cycle
- in_ready  output  1  block accepts d/s this cycle (combinational)
- y0  output  W  channel 0 data (registered)
- valid0  output  1  y0 holds an undelivered word
- ready0  input  1  channel 0 consumer takes y0 this cycle
- y1  output  W  channel 1 data (registered)
- valid1  output  1  y1 holds an undelivered word
- ready1  input  1  channel 1 consumer takes y1 this cycle
- cnt0  output  CW  words delivered on channel 0
- cnt1  output  CW  words delivered on channel 1

Behaviour:
- Reset:
  - Asserting rst_n=0 at any time (including mid-transfer) immediately clears y0, y1, valid0, valid1, cnt0 and cnt1 to 0.
  - Any buffered words are discarded.
  - in_ready follows its combinational equation.
- Handshake definitions:
  - Input accept: in_valid & in_ready.
  - Output k pop: valid_k & ready_k.
- in_ready = (s==0) ? (!valid0 | ready0) : (!valid1 | ready1).
  - Depends only on the selected channel; the other channel never stalls the input.
- Accept to channel k, latency 1: on the next edge, y_k <= d and valid_k <= 1.
- Pop of channel k without accept to k: valid_k <= 0. y_k holds its last value (not cleared).
- Simultaneous pop of k and accept to k: y_k <= d, valid_k stays 1. Full throughput, no bubble.
- Simultaneous accept to one channel and pop on the other: both take effect independently.
- Both channels may pop in the same cycle.
- Full channel (valid_k=1, ready_k=0) while s=k and in_valid=1:
  - in_ready=0; no state change.
  - y_k is stable until popped.
  - The producer must hold d/s; the block does not rely on this.
- in_valid=0: no buffer writes regardless of in_ready. s and d are don't-care.
- Counters:
  - cnt_k increments by 1 on every pop of channel k.
  - Modulo 2^CW; wraps from 2^CW-1 to 0 with no flag.
  - Counters are unaffected by accepts.
- Output stability: while valid_k=1 and ready_k=0, y_k and valid_k must not change.
- No combinational path from d to y0/y1.
  - in_ready's only combinational inputs are s, valid0/1 and ready0/1.

Test Plan:
1. Reset and route to channel 0:
   - Hold rst_n=0, then release.
   - Present d=8'hAA, s=0, in_valid=1 for one cycle with ready0=1.
   - Expect next cycle: valid0=1, y0=8'hAA, valid1=0.
   - Expect the following cycle: valid0=0 and cnt0=1.
2. Route to channel 1 with backpressure:
   - Send d=8'h53, s=1 with ready1=0; then present d=8'h11, s=1.
   - Expect in_ready=0, y1=8'h53 held and valid1=1 for 3 cycles.
   - Raise ready1: expect 8'h53 popped, 8'h11 loaded the same edge, valid1 still 1, then cnt1=1.
3. Independence:
   - Stall channel 0 with ready0=0 and valid0=1 (y0=8'hFF).
   - Stream 8'h01, 8'h02, 8'h03 to s=1 with ready1=1.
   - Expect in_ready=1 each cycle, y1 sequence 01/02/03 back-to-back, y0 stays 8'hFF, cnt1=3.
4. Back-to-back full throughput on one channel:
   - Send 8 consecutive words 8'h10..8'h17 on s=0 with ready0=1.
   - Expect in_ready=1 throughout, no bubble on valid0, cnt0=8.
5. Counter wrap:
   - With CW=8, deliver 256 words on channel 0.
   - Expect cnt0 to read 8'hFF after 255 pops and 8'h00 after 256; cnt1 unchanged.
6. Reset mid-operation:
   - With valid0=1 and valid1=1 and cnt0=5, pulse rst_n=0 asynchronously between clock edges.
   - Expect valid0, valid1, y0, y1, cnt0 and cnt1 to go to 0 before the next edge, and remain 0 until new accepts.
